vx_counting_scoreboard: RTL and testbench

Issue-stage hazard tracker with per-register pending-write counters. It replaces the single in-use bit with a CTR_W-bit counter per (warp slot, register). Multiple outstanding writes to one rd are therefore allowed in WAW-relaxed mode, and several writeback ports can retire into the same slot in one cycle. It sits between the ibuffer and the operand-collect/dispatch stage, with one lane per issue slot, and adds a registered staging stage on the output.

---
 rtl/VX_gpu_pkg.sv | 14 +
 rtl/VX_stream_buffer.sv | 42 ++++
 rtl/vx_sb_counter_bank.sv | 90 +++++++++
 rtl/vx_counting_scoreboard.sv | 128 ++++++++++++
 tb/tb_vx_counting_scoreboard.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/VX_gpu_pkg.sv
// Shared scoreboard types: warp/register index widths and the writeback tag.
package VX_gpu_pkg;

    localparam int SB_WARPS = 4;
    localparam int SB_REGS  = 64;
    localparam int WIS_W    = (SB_WARPS > 1) ? $clog2(SB_WARPS) : 1;
    localparam int NR_W     = $clog2(SB_REGS);

    typedef struct packed {
        logic [WIS_W-1:0] wis;
        logic [NR_W-1:0]  rd;
    } sb_wb_t;

endpackage

// File: rtl/VX_stream_buffer.sv
// Two-entry skid buffer: registered valid/data out, ready from skid occupancy.
module VX_stream_buffer #(
    parameter int DATAW = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [DATAW-1:0] data_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [DATAW-1:0] data_out
);

    logic             skid_v;
    logic [DATAW-1:0] skid_d;

    assign ready_in = !skid_v;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            skid_v    <= 1'b0;
            skid_d    <= '0;
        end else if (!valid_out || ready_out) begin
            if (skid_v) begin
                valid_out <= 1'b1;
                data_out  <= skid_d;
                skid_v    <= 1'b0;
            end else begin
                valid_out <= valid_in;
                if (valid_in)
                    data_out <= data_in;
            end
        end else if (valid_in && !skid_v) begin
            skid_v <= 1'b1;
            skid_d <= data_in;
        end
    end

endmodule

// File: rtl/vx_sb_counter_bank.sv
// One lane's pending-write counters: lookups, inc/multi-dec update,
// per-warp busy reduction and sticky underflow.
module vx_sb_counter_bank
    import VX_gpu_pkg::*;
#(
    parameter int WARPS = SB_WARPS,
    parameter int REGS  = SB_REGS,
    parameter int NRP   = 4,
    parameter int NWB   = 2,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIS_W-1:0] rd_wis,
    input  logic [NR_W-1:0]  rd_reg [NRP],
    output logic [CTR_W-1:0] rd_ctr [NRP],
    input  logic             inc_en,
    input  sb_wb_t           inc,
    input  logic [NWB-1:0]   ret_en,
    input  sb_wb_t           ret [NWB],
    output logic [WARPS-1:0] warp_busy,
    output logic             underflow
);

    localparam int SW = CTR_W + $clog2(NWB + 1);
    localparam logic [SW-1:0] CMAX = SW'((1 << CTR_W) - 1);

    logic [CTR_W-1:0] ctr    [WARPS][REGS];
    logic [CTR_W-1:0] ctr_nx [WARPS][REGS];
    logic [WARPS-1:0] busy_nx;
    logic [SW-1:0]    sum;
    logic [SW-1:0]    dec;
    logic             uf_nx;
    logic             ovf;

    always_comb begin
        for (int k = 0; k < NRP; k++)
            rd_ctr[k] = ctr[rd_wis][rd_reg[k]];
    end

    // Net update per cell: issue and retires in one cycle cancel out.
    always_comb begin
        uf_nx   = 1'b0;
        ovf     = 1'b0;
        busy_nx = '0;
        sum     = '0;
        dec     = '0;
        for (int w = 0; w < WARPS; w++) begin
            for (int r = 0; r < REGS; r++) begin
                dec = '0;
                for (int p = 0; p < NWB; p++) begin
                    if (ret_en[p] && ret[p].wis == WIS_W'(w)
                            && ret[p].rd == NR_W'(r))
                        dec = dec + SW'(1);
                end
                sum = SW'(ctr[w][r])
                    + SW'(inc_en && inc.wis == WIS_W'(w)
                          && inc.rd == NR_W'(r));
                if (sum < dec) begin
                    uf_nx        = 1'b1;
                    ctr_nx[w][r] = '0;
                end else begin
                    if ((sum - dec) > CMAX)
                        ovf = 1'b1;
                    ctr_nx[w][r] = CTR_W'(sum - dec);
                end
                if (ctr_nx[w][r] != '0)
                    busy_nx[w] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < WARPS; w++)
                for (int r = 0; r < REGS; r++)
                    ctr[w][r] <= '0;
            warp_busy <= '0;
            underflow <= 1'b0;
        end else begin
            ctr       <= ctr_nx;
            warp_busy <= busy_nx;
            underflow <= underflow | uf_nx;
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!reset) !ovf);

endmodule

// File: rtl/vx_counting_scoreboard.sv
// Issue-stage hazard tracker with per-register pending-write counters
// and a registered staging buffer per issue lane.
module vx_counting_scoreboard
    import VX_gpu_pkg::*;
#(
    parameter int ISSUE_WIDTH    = 4,
    parameter int WARPS_PER_SLOT = SB_WARPS,
    parameter int NUM_REGS       = SB_REGS,
    parameter int NUM_RS         = 3,
    parameter int NUM_WB_PORTS   = 2,
    parameter int CTR_W          = 2,
    parameter int WAW_STALL      = 1,
    parameter int DATAW          = 128
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [ISSUE_WIDTH-1:0]                 in_valid,
    output logic [ISSUE_WIDTH-1:0]                 in_ready,
    input  logic [ISSUE_WIDTH*WIS_W-1:0]           in_wis,
    input  logic [ISSUE_WIDTH*NR_W-1:0]            in_rd,
    input  logic [ISSUE_WIDTH*NUM_RS*NR_W-1:0]     in_rs,
    input  logic [ISSUE_WIDTH-1:0]                 in_wb,
    input  logic [ISSUE_WIDTH*DATAW-1:0]           in_data,
    output logic [ISSUE_WIDTH-1:0]                 out_valid,
    input  logic [ISSUE_WIDTH-1:0]                 out_ready,
    output logic [ISSUE_WIDTH*DATAW-1:0]           out_data,
    input  logic [ISSUE_WIDTH*NUM_WB_PORTS-1:0]    wb_valid,
    input  logic [ISSUE_WIDTH*NUM_WB_PORTS-1:0]    wb_eop,
    input  logic [ISSUE_WIDTH*NUM_WB_PORTS*WIS_W-1:0] wb_wis,
    input  logic [ISSUE_WIDTH*NUM_WB_PORTS*NR_W-1:0]  wb_rd,
    output logic [ISSUE_WIDTH*WARPS_PER_SLOT-1:0]  warp_busy,
    output logic                                   err_underflow
);

    localparam int NRP = NUM_RS + 1;
    localparam int NWB = NUM_WB_PORTS;
    localparam logic [CTR_W-1:0] CMAX = '1;

    logic [ISSUE_WIDTH-1:0] lane_uf;

    for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_lane
        logic [WIS_W-1:0]  wis;
        logic [NR_W-1:0]   rd;
        logic [NR_W-1:0]   rreg [NRP];
        logic [CTR_W-1:0]  rctr [NRP];
        logic [NUM_RS-1:0] busy_rs;
        logic              busy_rd;
        logic              ops_ready;
        logic              stg_valid;
        logic              stg_ready;
        logic              inc_en;
        sb_wb_t            inc;
        logic [NWB-1:0]    ret_en;
        sb_wb_t            ret [NWB];

        assign wis = in_wis[i*WIS_W +: WIS_W];
        assign rd  = in_rd[i*NR_W +: NR_W];

        // Last lookup port is rd, the others are the sources.
        always_comb begin
            for (int k = 0; k < NUM_RS; k++)
                rreg[k] = in_rs[(i*NUM_RS+k)*NR_W +: NR_W];
            rreg[NUM_RS] = rd;
        end

        always_comb begin
            busy_rs = '0;
            for (int k = 0; k < NUM_RS; k++)
                busy_rs[k] = (rreg[k] != '0) && (rctr[k] != '0);
        end

        assign busy_rd = in_wb[i] && (rd != '0)
                       && ((WAW_STALL != 0) ? (rctr[NUM_RS] != '0)
                                            : (rctr[NUM_RS] == CMAX));

        assign ops_ready = !(|busy_rs) && !busy_rd;
        assign stg_valid = in_valid[i] && ops_ready;
        assign in_ready[i] = reset && ops_ready && stg_ready;
        assign inc_en = in_valid[i] && in_ready[i] && in_wb[i]
                      && (rd != '0);
        assign inc = '{wis: wis, rd: rd};

        always_comb begin
            for (int p = 0; p < NWB; p++) begin
                ret[p].wis = wb_wis[(i*NWB+p)*WIS_W +: WIS_W];
                ret[p].rd  = wb_rd[(i*NWB+p)*NR_W +: NR_W];
                ret_en[p]  = wb_valid[i*NWB+p] && wb_eop[i*NWB+p]
                           && (ret[p].rd != '0);
            end
        end

        vx_sb_counter_bank #(
            .WARPS (WARPS_PER_SLOT),
            .REGS  (NUM_REGS),
            .NRP   (NRP),
            .NWB   (NWB),
            .CTR_W (CTR_W)
        ) u_bank (
            .clk       (clk),
            .reset     (reset),
            .rd_wis    (wis),
            .rd_reg    (rreg),
            .rd_ctr    (rctr),
            .inc_en    (inc_en),
            .inc       (inc),
            .ret_en    (ret_en),
            .ret       (ret),
            .warp_busy (warp_busy[i*WARPS_PER_SLOT +: WARPS_PER_SLOT]),
            .underflow (lane_uf[i])
        );

        VX_stream_buffer #(
            .DATAW (DATAW)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .valid_in  (stg_valid),
            .ready_in  (stg_ready),
            .data_in   (in_data[i*DATAW +: DATAW]),
            .valid_out (out_valid[i]),
            .ready_out (out_ready[i]),
            .data_out  (out_data[i*DATAW +: DATAW])
        );
    end

    assign err_underflow = |lane_uf;

endmodule

// File: tb/tb_vx_counting_scoreboard.sv
// Bench: two scoreboards (WAW stall on / off) against a counting model.
module tb_vx_counting_scoreboard;

    logic clk = 1'b0;
    logic reset = 1'b0;
    bit   chk_on = 1'b0;

    logic [3:0]   in_valid [2];
    logic [3:0]   in_ready [2];
    logic [7:0]   in_wis [2];
    logic [23:0]  in_rd [2];
    logic [71:0]  in_rs [2];
    logic [3:0]   in_wb [2];
    logic [511:0] in_data [2];
    logic [3:0]   out_valid [2];
    logic [3:0]   out_ready [2];
    logic [511:0] out_data [2];
    logic [7:0]   wb_valid [2];
    logic [7:0]   wb_eop [2];
    logic [15:0]  wb_wis [2];
    logic [47:0]  wb_rd [2];
    logic [15:0]  warp_busy [2];
    logic         err_uf [2];

    int n_chk = 0;
    int n_fail = 0;

    // model: pending count per (dut, lane, warp, reg), staged entries
    int           mc [2][4][4][64];
    logic [127:0] mq [2][4][2];
    int           mn [2][4];
    bit           merr [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        vx_counting_scoreboard #(
            .WAW_STALL (g == 0 ? 1 : 0)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .in_valid      (in_valid[g]),
            .in_ready      (in_ready[g]),
            .in_wis        (in_wis[g]),
            .in_rd         (in_rd[g]),
            .in_rs         (in_rs[g]),
            .in_wb         (in_wb[g]),
            .in_data       (in_data[g]),
            .out_valid     (out_valid[g]),
            .out_ready     (out_ready[g]),
            .out_data      (out_data[g]),
            .wb_valid      (wb_valid[g]),
            .wb_eop        (wb_eop[g]),
            .wb_wis        (wb_wis[g]),
            .wb_rd         (wb_rd[g]),
            .warp_busy     (warp_busy[g]),
            .err_underflow (err_uf[g])
        );
    end

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_ready(input int d, input int l);
        int w;
        int r;
        if (!reset) return 1'b0;
        if (mn[d][l] >= 2) return 1'b0;
        w = int'(in_wis[d][l*2 +: 2]);
        for (int k = 0; k < 3; k++) begin
            r = int'(in_rs[d][(l*3+k)*6 +: 6]);
            if (r != 0 && mc[d][l][w][r] != 0) return 1'b0;
        end
        r = int'(in_rd[d][l*6 +: 6]);
        if (in_wb[d][l] && r != 0) begin
            if (d == 0 && mc[d][l][w][r] != 0) return 1'b0;
            if (d == 1 && mc[d][l][w][r] == 3) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic m_step(input int d, input int l);
        bit f;
        bit cv [3];
        int cw [3];
        int cr [3];
        int net;
        int v;
        bit seen;
        f = in_valid[d][l] && m_ready(d, l);
        cw[0] = int'(in_wis[d][l*2 +: 2]);
        cr[0] = int'(in_rd[d][l*6 +: 6]);
        cv[0] = f && in_wb[d][l] && cr[0] != 0;
        for (int p = 0; p < 2; p++) begin
            cw[p+1] = int'(wb_wis[d][(l*2+p)*2 +: 2]);
            cr[p+1] = int'(wb_rd[d][(l*2+p)*6 +: 6]);
            cv[p+1] = wb_valid[d][l*2+p] && wb_eop[d][l*2+p]
                    && cr[p+1] != 0;
        end
        for (int j = 0; j < 3; j++) begin
            seen = 1'b0;
            for (int j2 = 0; j2 < j; j2++)
                if (cv[j2] && cw[j2] == cw[j] && cr[j2] == cr[j])
                    seen = 1'b1;
            if (cv[j] && !seen) begin
                net = 0;
                if (cv[0] && cw[0] == cw[j] && cr[0] == cr[j]) net++;
                for (int p = 1; p < 3; p++)
                    if (cv[p] && cw[p] == cw[j] && cr[p] == cr[j]) net--;
                v = mc[d][l][cw[j]][cr[j]] + net;
                if (v < 0) begin
                    merr[d] = 1'b1;
                    v = 0;
                end
                if (v > 3) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL model_ovf d%0d l%0d: count %0d limit 3",
                             d, l, v);
                end
                mc[d][l][cw[j]][cr[j]] = v;
            end
        end
        if (mn[d][l] > 0 && out_ready[d][l]) begin
            mq[d][l][0] = mq[d][l][1];
            mn[d][l]--;
        end
        if (f) begin
            mq[d][l][mn[d][l]] = in_data[d][l*128 +: 128];
            mn[d][l]++;
        end
    endtask

    task automatic m_clear();
        for (int d = 0; d < 2; d++) begin
            merr[d] = 1'b0;
            for (int l = 0; l < 4; l++) begin
                mn[d][l] = 0;
                for (int w = 0; w < 4; w++)
                    for (int r = 0; r < 64; r++)
                        mc[d][l][w][r] = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        if (reset)
            for (int d = 0; d < 2; d++)
                for (int l = 0; l < 4; l++)
                    m_step(d, l);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                logic [15:0] eb;
                eb = '0;
                for (int l = 0; l < 4; l++) begin
                    check($sformatf("in_ready d%0d l%0d", d, l),
                          in_ready[d][l], m_ready(d, l));
                    check($sformatf("out_valid d%0d l%0d", d, l),
                          out_valid[d][l], mn[d][l] > 0);
                    if (mn[d][l] > 0)
                        check($sformatf("out_data d%0d l%0d", d, l),
                              out_data[d][l*128 +: 128], mq[d][l][0]);
                    for (int w = 0; w < 4; w++)
                        for (int r = 0; r < 64; r++)
                            if (mc[d][l][w][r] != 0) eb[l*4+w] = 1'b1;
                end
                check($sformatf("warp_busy d%0d", d), warp_busy[d], eb);
                check($sformatf("err_underflow d%0d", d), err_uf[d], merr[d]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic iss(input int d, input int l, input int wis, input int rd,
                       input int rs0, input int rs1, input int rs2,
                       input bit wb, input logic [127:0] data);
        in_valid[d][l] = 1'b1;
        in_wis[d][l*2 +: 2] = 2'(wis);
        in_rd[d][l*6 +: 6] = 6'(rd);
        in_rs[d][l*18 +: 6] = 6'(rs0);
        in_rs[d][l*18+6 +: 6] = 6'(rs1);
        in_rs[d][l*18+12 +: 6] = 6'(rs2);
        in_wb[d][l] = wb;
        in_data[d][l*128 +: 128] = data;
    endtask

    task automatic idle(input int d, input int l);
        in_valid[d][l] = 1'b0;
    endtask

    task automatic wbs(input int d, input int l, input int p,
                       input int wis, input int rd);
        wb_valid[d][l*2+p] = 1'b1;
        wb_eop[d][l*2+p] = 1'b1;
        wb_wis[d][(l*2+p)*2 +: 2] = 2'(wis);
        wb_rd[d][(l*2+p)*6 +: 6] = 6'(rd);
    endtask

    task automatic wbclr(input int d);
        wb_valid[d] = '0;
        wb_eop[d] = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rx [$];
        int  idx;
        bit  r;
        bit  v;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = '0; in_wis[d] = '0; in_rd[d] = '0;
            in_rs[d] = '0; in_wb[d] = '0; in_data[d] = '0;
            out_ready[d] = '1; wb_valid[d] = '0; wb_eop[d] = '0;
            wb_wis[d] = '0; wb_rd[d] = '0;
        end
        m_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready[0], 4'h0);
        check("rst_out_valid", out_valid[1], 4'h0);
        check("rst_warp_busy", warp_busy[0], 16'h0);
        check("rst_err", err_uf[0], 1'b0);
        chk_on = 1'b1;
        reset = 1'b1;
        step();

        // RAW stall with WAW stall enabled, lane 0 of dut 0
        iss(0, 0, 0, 5, 1, 2, 3, 1'b1, 128'hA1);
        @(negedge clk);
        check("t1_issue_ready", in_ready[0][0], 1'b1);
        step();
        iss(0, 0, 0, 0, 5, 0, 0, 1'b0, 128'hA2);
        @(negedge clk);
        check("t1_raw_stall", in_ready[0][0], 1'b0);
        check("t1_lat_valid", out_valid[0][0], 1'b1);
        check("t1_lat_data", out_data[0][127:0], 128'hA1);
        check("t1_warp_busy", warp_busy[0][0], 1'b1);
        step();
        wbs(0, 0, 0, 0, 5);
        wb_eop[0][0] = 1'b0;
        @(negedge clk);
        check("t1_noneop_stall", in_ready[0][0], 1'b0);
        step();
        wb_eop[0][0] = 1'b1;
        @(negedge clk);
        check("t1_retire_cycle", in_ready[0][0], 1'b0);
        step();
        wbclr(0);
        @(negedge clk);
        check("t1_ready_after", in_ready[0][0], 1'b1);
        check("t1_busy_clear", warp_busy[0][0], 1'b0);
        step();
        idle(0, 0);
        @(negedge clk);
        check("t1_out_valid", out_valid[0][0], 1'b1);
        check("t1_out_data", out_data[0][127:0], 128'hA2);
        step();

        // WAW relaxed: three writes to r7 fill the counter
        for (int i = 0; i < 3; i++) begin
            iss(1, 0, 1, 7, 0, 0, 0, 1'b1, 128'(32'hB0 + i));
            @(negedge clk);
            check($sformatf("t2_accept_%0d", i), in_ready[1][0], 1'b1);
            step();
        end
        iss(1, 0, 1, 7, 0, 0, 0, 1'b1, 128'hB3);
        @(negedge clk);
        check("t2_fourth_stall", in_ready[1][0], 1'b0);
        step();
        wbs(1, 0, 0, 1, 7);
        @(negedge clk);
        check("t2_retire_cycle", in_ready[1][0], 1'b0);
        step();
        wbclr(1);
        @(negedge clk);
        check("t2_fourth_accept", in_ready[1][0], 1'b1);
        step();
        iss(1, 0, 1, 7, 0, 0, 0, 1'b1, 128'hB4);
        @(negedge clk);
        check("t2_full_again", in_ready[1][0], 1'b0);
        step();
        idle(1, 0);
        wbs(1, 0, 0, 1, 7);
        wbs(1, 0, 1, 1, 7);
        step();
        wbclr(1);
        wbs(1, 0, 0, 1, 7);
        step();
        wbclr(1);
        @(negedge clk);
        check("t2_drained", warp_busy[1][1], 1'b0);
        step();

        // two ports retire the same register in one cycle
        for (int i = 0; i < 2; i++) begin
            iss(1, 1, 2, 9, 0, 0, 0, 1'b1, 128'(32'hC0 + i));
            @(negedge clk);
            check($sformatf("t3_accept_%0d", i), in_ready[1][1], 1'b1);
            step();
        end
        idle(1, 1);
        @(negedge clk);
        check("t3_busy", warp_busy[1][6], 1'b1);
        wbs(1, 1, 0, 2, 9);
        wbs(1, 1, 1, 2, 9);
        step();
        wbclr(1);
        @(negedge clk);
        check("t3_busy_fall", warp_busy[1][6], 1'b0);
        check("t3_no_err", err_uf[1], 1'b0);
        step();

        // issue and retire on the same cell cancel
        iss(1, 2, 1, 4, 0, 0, 0, 1'b1, 128'hD0);
        @(negedge clk);
        check("t4_first", in_ready[1][2], 1'b1);
        step();
        iss(1, 2, 1, 4, 0, 0, 0, 1'b1, 128'hD1);
        wbs(1, 2, 0, 1, 4);
        @(negedge clk);
        check("t4_iss_ret", in_ready[1][2], 1'b1);
        step();
        wbclr(1);
        iss(1, 2, 1, 0, 4, 0, 0, 1'b0, 128'hD2);
        @(negedge clk);
        check("t4_reader_stall", in_ready[1][2], 1'b0);
        check("t4_busy", warp_busy[1][9], 1'b1);
        step();
        wbs(1, 2, 0, 1, 4);
        @(negedge clk);
        check("t4_reader_ret_cycle", in_ready[1][2], 1'b0);
        step();
        wbclr(1);
        @(negedge clk);
        check("t4_reader_go", in_ready[1][2], 1'b1);
        step();
        idle(1, 2);

        // retire with nothing pending
        wbs(0, 3, 0, 0, 3);
        @(negedge clk);
        check("t5_err_before", err_uf[0], 1'b0);
        step();
        wbclr(0);
        @(negedge clk);
        check("t5_err_set", err_uf[0], 1'b1);
        check("t5_ctr_zero", warp_busy[0][12], 1'b0);
        repeat (3) step();
        @(negedge clk);
        check("t5_sticky", err_uf[0], 1'b1);
        step();

        // stalled stream through the skid buffer
        out_ready[0][0] = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            iss(0, 0, 0, 0, 0, 0, 0, 1'b0, 128'(32'hE0 + idx));
            @(negedge clk);
            r = in_ready[0][0];
            step();
            if (r) idx++;
        end
        @(negedge clk);
        check("t6_accepts_stall", idx, 2);
        check("t6_hold_valid", out_valid[0][0], 1'b1);
        check("t6_hold_data", out_data[0][127:0], 128'hE0);
        step();
        out_ready[0][0] = 1'b1;
        for (int c = 0; c < 20 && (idx < 6 || rx.size() < 6); c++) begin
            if (idx < 6) iss(0, 0, 0, 0, 0, 0, 0, 1'b0, 128'(32'hE0 + idx));
            else idle(0, 0);
            @(negedge clk);
            r = in_ready[0][0];
            v = in_valid[0][0];
            if (out_valid[0][0] && out_ready[0][0])
                rx.push_back(out_data[0][127:0]);
            step();
            if (r && v) idx++;
        end
        idle(0, 0);
        check("t6_rx_count", rx.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < rx.size())
                check($sformatf("t6_order_%0d", i), rx[i], 128'(32'hE0 + i));

        // async reset while the stage is stalled
        out_ready[0][0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iss(0, 0, 0, 0, 0, 0, 0, 1'b0, 128'(32'hF0 + i));
            step();
        end
        @(negedge clk);
        check("t7_stalled_valid", out_valid[0][0], 1'b1);
        #2;
        reset = 1'b0;
        m_clear();
        #1;
        check("t7_rst_out_valid", out_valid[0][0], 1'b0);
        check("t7_rst_in_ready", in_ready[0][0], 1'b0);
        idle(0, 0);
        @(negedge clk);
        reset = 1'b1;
        out_ready[0][0] = 1'b1;
        step();
        @(negedge clk);
        check("t7_busy0", warp_busy[0], 16'h0);
        check("t7_err0", err_uf[0], 1'b0);
        check("t7_out_valid", out_valid[0][0], 1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
